// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared types for the 1-bit ALU result checker and its golden model
package alu_chk_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_INV = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    a;
        logic    b;
        alu_op_e op;
        logic    cin;
        logic    binv;
    } alu_vec_t;

    typedef struct packed {
        logic y0;
        logic y1;
        logic error;
        logic zero;
    } alu_res_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPORT = 2'd2
    } chk_state_e;

endpackage

// File: rtl/alu_result_checker_if.sv
// rtl/alu_result_checker_if.sv - vector handshake, sampled ALU outputs and result strobe
interface alu_result_checker_if;

    logic vec_valid;
    logic vec_ready;
    logic vec_a;
    logic vec_b;
    logic vec_op0;
    logic vec_op1;
    logic vec_cin;
    logic vec_binv;
    logic dut_y0;
    logic dut_y1;
    logic dut_error;
    logic dut_zero;
    logic chk_valid;
    logic chk_pass;

    modport master (
        output vec_valid, vec_a, vec_b, vec_op0, vec_op1, vec_cin, vec_binv,
        output dut_y0, dut_y1, dut_error, dut_zero,
        input  vec_ready, chk_valid, chk_pass
    );

    modport slave (
        input  vec_valid, vec_a, vec_b, vec_op0, vec_op1, vec_cin, vec_binv,
        input  dut_y0, dut_y1, dut_error, dut_zero,
        output vec_ready, chk_valid, chk_pass
    );

endinterface

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational golden model of the 1-bit ALU
module alu_ref_model
    import alu_chk_pkg::*;
(
    input  alu_vec_t vec,
    output alu_res_t res
);

    logic bx;

    always_comb begin
        bx  = vec.b ^ vec.binv;
        res = '0;
        case (vec.op)
            OP_AND: res.y0 = vec.a & bx;
            OP_OR:  res.y0 = vec.a | bx;
            OP_ADD: begin
                res.y0 = vec.a ^ bx ^ vec.cin;
                res.y1 = (vec.a & bx) | (vec.a & vec.cin) | (bx & vec.cin);
            end
            default: res.error = 1'b1;
        endcase
        // the invalid opcode forces zero low even though y0 is 0
        if (vec.op != OP_INV) begin
            res.zero = ~res.y0;
        end
    end

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - accepts an applied ALU vector, waits the settle time, checks outputs, keeps statistics
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_stats,
    alu_result_checker_if.slave  bus,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic                 sticky_fail
);

    localparam int               SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [SET_W-1:0] settle_q;
    alu_vec_t         vec_in;
    alu_vec_t         vec_q;
    alu_res_t         exp_res;
    alu_res_t         dut_res;
    logic             pass_q;
    logic             vec_ready;
    logic             chk_valid;
    logic             accept;
    logic             sample;

    always_comb begin
        vec_in.a    = bus.vec_a;
        vec_in.b    = bus.vec_b;
        vec_in.op   = alu_op_e'({bus.vec_op1, bus.vec_op0});
        vec_in.cin  = bus.vec_cin;
        vec_in.binv = bus.vec_binv;

        dut_res.y0    = bus.dut_y0;
        dut_res.y1    = bus.dut_y1;
        dut_res.error = bus.dut_error;
        dut_res.zero  = bus.dut_zero;
    end

    alu_ref_model u_ref (
        .vec (vec_q),
        .res (exp_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_ready = 1'b0;
        chk_valid = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE: begin
                vec_ready = 1'b1;
                if (bus.vec_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (settle_q == '0) begin
                    sample  = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                chk_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // the DUT outputs are looked at only on the WAIT exit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_q <= '0;
            vec_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            if (accept) begin
                vec_q    <= vec_in;
                settle_q <= SET_LOAD;
            end else if (state_q == WAIT && settle_q != '0) begin
                settle_q <= settle_q - SET_W'(1);
            end
            if (sample) begin
                pass_q <= (dut_res == exp_res);
            end
        end
    end

    // a clear in the REPORT cycle wins, so that vector is never counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_count      <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            sticky_fail    <= 1'b0;
        end else if (clr_stats) begin
            vec_count      <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            sticky_fail    <= 1'b0;
        end else if (chk_valid) begin
            if (vec_count != CNT_MAX) begin
                vec_count <= vec_count + CNT_W'(1);
            end
            if (!pass_q) begin
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (!sticky_fail) begin
                    first_fail_idx <= vec_count;
                    sticky_fail    <= 1'b1;
                end
            end
        end
    end

    assign bus.vec_ready = vec_ready;
    assign bus.chk_valid = chk_valid;
    assign bus.chk_pass  = pass_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - scoreboard bench for alu_result_checker
module tb_alu_result_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_stats;
    logic       vec_valid;
    logic [5:0] vec_bits;   // {a, b, op1, op0, cin, binv}
    logic [3:0] dut_drive;  // {y0, y1, error, zero}
    logic [7:0] vc0, ec0, ff0;
    logic       sf0;
    logic [1:0] vc1, ec1, ff1;
    logic       sf1;
    int         checks  = 0;
    int         errors  = 0;
    int         strobes = 0;
    int         cyc     = 0;
    int         last_acc = 0;
    logic       sb_q[$];

    alu_result_checker_if bus0 ();
    alu_result_checker_if bus1 ();

    assign bus0.vec_valid = vec_valid;
    assign bus0.vec_a     = vec_bits[5];
    assign bus0.vec_b     = vec_bits[4];
    assign bus0.vec_op1   = vec_bits[3];
    assign bus0.vec_op0   = vec_bits[2];
    assign bus0.vec_cin   = vec_bits[1];
    assign bus0.vec_binv  = vec_bits[0];
    assign bus0.dut_y0    = dut_drive[3];
    assign bus0.dut_y1    = dut_drive[2];
    assign bus0.dut_error = dut_drive[1];
    assign bus0.dut_zero  = dut_drive[0];
    assign bus1.vec_valid = vec_valid;
    assign bus1.vec_a     = vec_bits[5];
    assign bus1.vec_b     = vec_bits[4];
    assign bus1.vec_op1   = vec_bits[3];
    assign bus1.vec_op0   = vec_bits[2];
    assign bus1.vec_cin   = vec_bits[1];
    assign bus1.vec_binv  = vec_bits[0];
    assign bus1.dut_y0    = dut_drive[3];
    assign bus1.dut_y1    = dut_drive[2];
    assign bus1.dut_error = dut_drive[1];
    assign bus1.dut_zero  = dut_drive[0];

    alu_result_checker #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .clr_stats      (clr_stats),
        .bus            (bus0),
        .vec_count      (vc0),
        .err_count      (ec0),
        .first_fail_idx (ff0),
        .sticky_fail    (sf0)
    );

    alu_result_checker #(.SETTLE_CYCLES(1), .CNT_W(2)) u_sat (
        .clk            (clk),
        .reset          (reset),
        .clr_stats      (clr_stats),
        .bus            (bus1),
        .vec_count      (vc1),
        .err_count      (ec1),
        .first_fail_idx (ff1),
        .sticky_fail    (sf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_res(input logic [5:0] v);
        logic       a;
        logic       bx;
        logic       cin;
        logic [1:0] op;
        logic [1:0] sum;
        logic       y0;
        logic       y1;
        a   = v[5];
        bx  = v[4] ^ v[0];
        op  = v[3:2];
        cin = v[1];
        sum = {1'b0, a} + {1'b0, bx} + {1'b0, cin};
        if (op == 2'b11) return 4'b0010;
        y0 = (op == 2'b00) ? (a & bx) : (op == 2'b01) ? (a | bx) : sum[0];
        y1 = (op == 2'b10) ? sum[1] : 1'b0;
        return {y0, y1, 1'b0, ~y0};
    endfunction

    task automatic send_vec(input logic [5:0] v, input logic [3:0] fault, input bit hold);
        int n;
        vec_bits  = v;
        vec_valid = 1'b1;
        n = 0;
        while (bus0.vec_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_seen", bus0.vec_ready, 1);
        if (bus0.vec_ready === 1'b1) begin
            sb_q.push_back(fault == 4'b0000);
            last_acc = cyc;
        end
        @(negedge clk);
        dut_drive = ref_res(v) ^ fault;
        if (!hold) vec_valid = 1'b0;
    endtask

    task automatic wait_report(output int n);
        n = 1;
        while (bus0.chk_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("report_seen", bus0.chk_valid, 1);
    endtask

    always @(negedge clk) begin
        if (bus0.chk_valid === 1'b1) begin
            strobes++;
            check_eq("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) check_eq("sb_pass", bus0.chk_pass, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int first_acc;
        int s0;
        reset     = 1'b1;
        clr_stats = 1'b0;
        vec_valid = 1'b0;
        vec_bits  = '0;
        dut_drive = '0;
        first_acc = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("idle_ready", bus0.vec_ready, 1);
        check_eq("idle_chk_valid", bus0.chk_valid, 0);
        check_eq("idle_strobes", strobes, 0);
        check_eq("idle_pass", bus0.chk_pass, 0);
        check_eq("idle_vec_count", vc0, 0);
        check_eq("idle_err_count", ec0, 0);
        check_eq("idle_first_fail", ff0, 0);
        check_eq("idle_sticky", sf0, 0);

        // ADD 1+1+1: Y0=1 Y1=1
        send_vec(6'b111010, 4'b0000, 1'b0);
        wait_report(n);
        check_eq("latency", n, 5);
        check_eq("add_pass", bus0.chk_pass, 1);
        @(negedge clk);
        check_eq("add_vec_count", vc0, 1);
        check_eq("add_err_count", ec0, 0);
        check_eq("add_strobe_gone", bus0.chk_valid, 0);
        check_eq("add_pass_held", bus0.chk_pass, 1);

        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check_eq("clr_vec_count", vc0, 0);

        // invalid op with Error driven low
        send_vec(6'b001100, 4'b0010, 1'b0);
        wait_report(n);
        check_eq("inv_pass", bus0.chk_pass, 0);
        @(negedge clk);
        check_eq("inv_err_count", ec0, 1);
        check_eq("inv_first_fail", ff0, 0);
        check_eq("inv_sticky", sf0, 1);
        send_vec(6'b100000, 4'b1000, 1'b0);
        wait_report(n);
        @(negedge clk);
        check_eq("fail2_err_count", ec0, 2);
        check_eq("fail2_vec_count", vc0, 2);
        check_eq("fail2_first_fail", ff0, 0);

        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send_vec(i[5:0], 4'b0000, 1'b1);
            if (i == 0) first_acc = last_acc;
        end
        vec_valid = 1'b0;
        wait_report(n);
        @(negedge clk);
        check_eq("sweep_vec_count", vc0, 64);
        check_eq("sweep_err_count", ec0, 0);
        check_eq("sweep_span", last_acc - first_acc, 63 * 6);

        // reset in the middle of WAIT
        send_vec(6'b100100, 4'b0000, 1'b0);
        @(negedge clk);
        s0 = strobes;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check_eq("rst_ready", bus0.vec_ready, 1);
        check_eq("rst_chk_valid", bus0.chk_valid, 0);
        check_eq("rst_pass", bus0.chk_pass, 0);
        check_eq("rst_vec_count", vc0, 0);
        check_eq("rst_err_count", ec0, 0);
        check_eq("rst_first_fail", ff0, 0);
        check_eq("rst_sticky", sf0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("rst_no_strobe", strobes, s0);
        send_vec(6'b010101, 4'b0000, 1'b0);
        wait_report(n);
        @(negedge clk);
        check_eq("post_rst_vec_count", vc0, 1);
        check_eq("post_rst_pass", bus0.chk_pass, 1);

        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_vec(6'b110000, 4'b0001, 1'b0);
            @(negedge clk);
            check_eq("sat_strobe", bus1.chk_valid, 1);
            check_eq("sat_pass", bus1.chk_pass, 0);
            wait_report(n);
            @(negedge clk);
        end
        check_eq("sat_vec_count", vc1, 3);
        check_eq("sat_err_count", ec1, 3);
        check_eq("sat_first_fail", ff1, 0);
        check_eq("sat_sticky", sf1, 1);
        check_eq("wide_vec_count", vc0, 5);
        check_eq("wide_err_count", ec0, 5);

        // clear coinciding with REPORT
        send_vec(6'b110000, 4'b0000, 1'b0);
        wait_report(n);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check_eq("clr_rep_vec_count", vc0, 0);
        check_eq("clr_rep_err_count", ec0, 0);
        check_eq("clr_rep_sticky", sf0, 0);
        check_eq("clr_rep_first_fail", ff0, 0);
        check_eq("clr_rep_pass", bus0.chk_pass, 1);
        check_eq("clr_rep_sat_count", vc1, 0);

        repeat (3) @(negedge clk);
        check_eq("sb_left", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
